uram_wght_fetch: RTL and testbench

// - Downstream consumer of the URAM weight store in the SNN core.
// - Accepts presynaptic spike events (neuron index) and streams that neuron's weight row to the

---
 rtl/uram_wght_fetch.sv | 213 +++++++++++++++++++++
 tb/tb_uram_wght_fetch.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uram_wght_fetch.sv
// -----------------------------------------------------------------------------
// uram_wght_fetch
//
// Purpose:
//   Turns presynaptic spike events (neuron index) into a stream of that
//   neuron's weight row read out of the attached weight URAM. A row is
//   WORDS_PER_ROW consecutive 64-bit words. A 2-entry output buffer absorbs
//   the 1-cycle URAM read latency, so downstream backpressure never loses a
//   word.
//
// Handshakes (both sides):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   A producer holding valid keeps its payload stable until that edge.
//   Valid never depends on ready. The spike side accepts only in IDLE.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   layer_base     first URAM word of the current layer (sampled on accept)
//   spk_valid/spk_ready/spk_idx   spike event input
//   ren/raddr/rdat URAM read port (rdat valid the cycle after ren)
//   wght_valid/wght_ready/wght_data/wght_last   weight beat output
//   addr_err       1-cycle pulse: event rejected, row runs past RAM_DEPTH
//   busy           FSM not IDLE or output buffer non-empty
//   dbg_state      current FSM state (0 IDLE, 1 ISSUE, 2 DRAIN)
//
// Optional feature (macro WFETCH_PERF_EN):
//   perf_evt_cnt, perf_stall_cnt, perf_err_cnt saturating counters.
// -----------------------------------------------------------------------------
module uram_wght_fetch #(
  parameter int RAM_DEPTH      = 10485,
  parameter int RAM_ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int WORDS_PER_ROW  = 4,
  parameter int SPK_IDX_W      = 12,
  parameter int BEAT_W         = $clog2(WORDS_PER_ROW + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [RAM_ADDR_WIDTH-1:0] layer_base,
  input  logic                      spk_valid,
  output logic                      spk_ready,
  input  logic [SPK_IDX_W-1:0]      spk_idx,
  output logic                      ren,
  output logic [RAM_ADDR_WIDTH-1:0] raddr,
  input  logic signed [63:0]        rdat,
  output logic                      wght_valid,
  input  logic                      wght_ready,
  output logic signed [63:0]        wght_data,
  output logic                      wght_last,
  output logic                      addr_err,
  output logic                      busy,
  output logic [1:0]                dbg_state
`ifdef WFETCH_PERF_EN
  ,
  output logic [31:0]               perf_evt_cnt,
  output logic [31:0]               perf_stall_cnt,
  output logic [15:0]               perf_err_cnt
`endif
);

  // Row address arithmetic is carried wide enough that no sum can wrap,
  // so an out-of-range row can never alias onto a legal one.
  localparam int ROW_W = RAM_ADDR_WIDTH + SPK_IDX_W + BEAT_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_ROW - 1);

  // FSM / issue state
  logic [1:0]                r_state;
  logic [1:0]                w_state_nxt;
  logic                      r_spk_ready;
  logic [RAM_ADDR_WIDTH-1:0] r_row_addr;
  logic [BEAT_W-1:0]         r_beat_cnt;
  logic                      r_inflight;
  logic                      r_inflight_last;
  logic                      r_addr_err;

  // 2-entry output buffer
  logic signed [63:0]        r_buf_data [0:1];
  logic                      r_buf_last [0:1];
  logic                      r_wr_ptr;
  logic                      r_rd_ptr;
  logic [1:0]                r_count;

  logic                      w_accept;
  logic [ROW_W-1:0]          w_row_start;
  logic [ROW_W-1:0]          w_row_end;
  logic                      w_row_ok;
  logic                      w_pop;
  logic [2:0]                w_credit;
  logic                      w_ren;
  logic                      w_ren_last;
  logic                      w_drained;

  assign w_accept    = spk_valid && r_spk_ready;
  assign w_row_start = ROW_W'(layer_base) + ROW_W'(spk_idx) * ROW_W'(WORDS_PER_ROW);
  assign w_row_end   = w_row_start + ROW_W'(WORDS_PER_ROW);
  assign w_row_ok    = (w_row_end <= ROW_W'(RAM_DEPTH));

  assign w_pop = (r_count != 2'd0) && wght_ready;

  // Slots that will be occupied once this cycle's pop and the in-flight
  // word land. Counting the current pop lets a new read go out in the same
  // cycle a slot frees up, which is what sustains one beat per cycle; a
  // read issued now lands next cycle, so this must stay below 2.
  assign w_credit   = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_ren      = (r_state == S_ISSUE) && (w_credit < 3'd2);
  assign w_ren_last = w_ren && (r_beat_cnt == LAST_BEAT);

  // Row is finished once nothing is in flight and the buffer is empty or
  // its final word is handing off this cycle.
  assign w_drained = !r_inflight &&
                     ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_row_ok) w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_ren_last)           w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drained)            w_state_nxt = S_IDLE;
      default:                           w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_spk_ready     <= 1'b0;
      r_row_addr      <= '0;
      r_beat_cnt      <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_addr_err      <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_spk_ready     <= (w_state_nxt == S_IDLE);
      r_addr_err      <= w_accept && !w_row_ok;
      r_inflight      <= w_ren;
      r_inflight_last <= w_ren_last;
      if (w_accept && w_row_ok) begin
        r_row_addr <= w_row_start[RAM_ADDR_WIDTH-1:0];
        r_beat_cnt <= '0;
      end else if (w_ren) begin
        r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
      end
    end
  end

  // Output buffer: push is the word returned for last cycle's read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_buf_last[0] <= 1'b0;
      r_buf_last[1] <= 1'b0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_count       <= 2'd0;
    end else begin
      if (r_inflight) begin
        r_buf_data[r_wr_ptr] <= rdat;
        r_buf_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({r_inflight, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign spk_ready  = r_spk_ready;
  assign ren        = w_ren;
  assign raddr      = w_ren ? (r_row_addr + RAM_ADDR_WIDTH'(r_beat_cnt)) : '0;
  assign wght_valid = (r_count != 2'd0);
  assign wght_data  = r_buf_data[r_rd_ptr];
  assign wght_last  = wght_valid && r_buf_last[r_rd_ptr];
  assign addr_err   = r_addr_err;
  assign busy       = (r_state != S_IDLE) || (r_count != 2'd0);
  assign dbg_state  = r_state;

`ifdef WFETCH_PERF_EN
  logic [31:0] r_perf_evt;
  logic [31:0] r_perf_stall;
  logic [15:0] r_perf_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_evt   <= '0;
      r_perf_stall <= '0;
      r_perf_err   <= '0;
    end else begin
      if (w_accept && w_row_ok && (r_perf_evt != '1))
        r_perf_evt <= r_perf_evt + 32'd1;
      if (wght_valid && !wght_ready && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
      if (r_addr_err && (r_perf_err != '1))
        r_perf_err <= r_perf_err + 16'd1;
    end
  end

  assign perf_evt_cnt   = r_perf_evt;
  assign perf_stall_cnt = r_perf_stall;
  assign perf_err_cnt   = r_perf_err;
`endif

endmodule

// File: tb/tb_uram_wght_fetch.sv
// -----------------------------------------------------------------------------
// tb_uram_wght_fetch
//
// Bench for uram_wght_fetch: a behavioural URAM answers reads one cycle
// later with an address-derived word; expected beats and read addresses
// come from hand-computed row start addresses.
// -----------------------------------------------------------------------------
module tb_uram_wght_fetch;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [13:0]        layer_base = '0;
  logic               spk_valid = 1'b0;
  logic               spk_ready;
  logic [11:0]        spk_idx = '0;
  logic               ren;
  logic [13:0]        raddr;
  logic signed [63:0] rdat = '0;
  logic               wght_valid;
  logic               wght_ready = 1'b1;
  logic signed [63:0] wght_data;
  logic               wght_last;
  logic               addr_err;
  logic               busy;
  logic [1:0]         dbg_state;
`ifdef WFETCH_PERF_EN
  logic [31:0]        perf_evt_cnt;
  logic [31:0]        perf_stall_cnt;
  logic [15:0]        perf_err_cnt;
`endif

  uram_wght_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .layer_base (layer_base),
    .spk_valid  (spk_valid),
    .spk_ready  (spk_ready),
    .spk_idx    (spk_idx),
    .ren        (ren),
    .raddr      (raddr),
    .rdat       (rdat),
    .wght_valid (wght_valid),
    .wght_ready (wght_ready),
    .wght_data  (wght_data),
    .wght_last  (wght_last),
    .addr_err   (addr_err),
    .busy       (busy),
    .dbg_state  (dbg_state)
`ifdef WFETCH_PERF_EN
    ,
    .perf_evt_cnt   (perf_evt_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_err_cnt   (perf_err_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- URAM model ----------------
  function automatic logic [63:0] word_of(input logic [13:0] a);
    return {16'hC0DE, 2'b00, a, 16'h5A5A ^ {2'b00, a}, 2'b11, ~a};
  endfunction

  always @(posedge clk) begin
    if (ren) rdat <= word_of(raddr);
  end

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q[$];   // {last, data}
  logic [13:0] addr_q[$];
  int n_chk  = 0;
  int n_pass = 0;
  int n_ren  = 0;
  int n_pop  = 0;
  int n_err  = 0;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic note_fail(input string msg);
    n_chk++;
    $display("FAIL %s", msg);
  endtask

  task automatic push_row(input logic [13:0] a);
    for (int i = 0; i < 4; i++) begin
      addr_q.push_back(a + 14'(i));
      exp_q.push_back({(i == 3), word_of(a + 14'(i))});
    end
  endtask

  logic               prev_stall = 1'b0;
  logic signed [63:0] prev_data  = '0;
  logic               prev_last  = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      n_ren      = n_pop;
    end else begin
      if (prev_stall)
        chk("stall_hold", 66'({wght_valid, wght_last, wght_data}), 66'({1'b1, prev_last, prev_data}));
      if (ren) begin
        n_ren++;
        if (addr_q.size() == 0) note_fail($sformatf("ren_unexpected: raddr=%0d, no read required", raddr));
        else chk("raddr", 66'(raddr), 66'(addr_q.pop_front()));
      end
      if (wght_valid && wght_ready) begin
        n_pop++;
        if (exp_q.size() == 0) note_fail($sformatf("beat_unexpected: data=0x%0h, no beat required", wght_data));
        else chk("beat", 66'({wght_last, wght_data}), 66'(exp_q.pop_front()));
      end
      if (ren) chk("outstanding_le_2", 66'((n_ren - n_pop) <= 2), 66'(1));
      if (addr_err) n_err++;
      prev_stall = wght_valid && !wght_ready;
      prev_data  = wght_data;
      prev_last  = wght_last;
    end
  end

  // ---------------- driver tasks ----------------
  // Caller is at posedge+#1 (or time 0).
  task automatic do_reset();
    rst = 1'b1;
    spk_valid = 1'b0;
    exp_q.delete();
    addr_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 66'({spk_ready, ren, raddr, wght_valid, wght_last, addr_err, busy, dbg_state}), 66'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_reset_spk_ready", 66'(spk_ready), 66'(1));
  endtask

  // Returns at accept edge + #1.
  task automatic send_spike(input logic [13:0] base, input logic [11:0] idx);
    bit done = 1'b0;
    @(posedge clk); #1;
    layer_base = base;
    spk_idx    = idx;
    spk_valid  = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (spk_ready) done = 1'b1;
    end
    if (!done) note_fail("spk_accept timeout");
    @(posedge clk); #1;
    spk_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk); #1;
      if (!busy && exp_q.size() == 0 && addr_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      note_fail($sformatf("%s drain timeout: %0d beats, %0d reads still owed", tag, exp_q.size(), addr_q.size()));
      exp_q.delete();
      addr_q.delete();
    end else begin
      chk({tag, "_spk_ready_idle"}, 66'(spk_ready), 66'(1));
    end
  endtask

  task automatic wait_beats(input int start, input int n);
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk); #1;
      if (n_pop - start >= n) done = 1'b1;
    end
    if (!done) note_fail("beat wait timeout");
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [13:0] base;
    logic [11:0] idx;
    logic [13:0] exp_addr;
    logic        exp_err;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  initial begin
    logic [2:0] cyc_exp[6];
    int s;
    int e0;
    bit done;

    vecs[0]  = '{14'd100,   12'd3,    14'd112,   1'b0};
    vecs[1]  = '{14'd100,   12'd0,    14'd100,   1'b0};
    vecs[2]  = '{14'd100,   12'd1,    14'd104,   1'b0};
    vecs[3]  = '{14'd0,     12'd0,    14'd0,     1'b0};
    vecs[4]  = '{14'd10480, 12'd2,    14'd0,     1'b1};  // 10488..10491
    vecs[5]  = '{14'd10481, 12'd0,    14'd10481, 1'b0};  // ends exactly at 10484
    vecs[6]  = '{14'd10482, 12'd0,    14'd0,     1'b1};  // 10485 is out of range
    vecs[7]  = '{14'd0,     12'd2620, 14'd10480, 1'b0};
    vecs[8]  = '{14'd0,     12'd2621, 14'd0,     1'b1};
    vecs[9]  = '{14'd8000,  12'd4095, 14'd0,     1'b1};  // 24380: would alias if truncated
    vecs[10] = '{14'd5000,  12'd100,  14'd5400,  1'b0};

    // {ren, wght_valid, wght_last} on the 6 cycles after accept
    cyc_exp = '{3'b100, 3'b100, 3'b110, 3'b110, 3'b010, 3'b011};

    do_reset();

    // Row fetch with exact cycle timing
    push_row(14'd112);
    send_spike(14'd100, 12'd3);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("row_timing_c%0d", k + 1), 66'({ren, wght_valid, wght_last}), 66'(cyc_exp[k]));
      if (k == 0) chk("row_busy_spk_ready", 66'({busy, spk_ready}), 66'(2'b10));
    end
    wait_idle("row");

    // Table-driven events
    for (int v = 0; v < NV; v++) begin
      e0 = n_err;
      if (!vecs[v].exp_err) push_row(vecs[v].exp_addr);
      send_spike(vecs[v].base, vecs[v].idx);
      wait_idle($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_addr_err_pulses", v), 66'(n_err - e0), 66'(vecs[v].exp_err));
    end

    // Backpressure: 5 cycles of wght_ready=0 after the first beat
    push_row(14'd128);
    s = n_pop;
    send_spike(14'd100, 12'd7);
    wait_beats(s, 1);
    wght_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_c%0d_ren_valid", k), 66'({ren, wght_valid}), 66'(2'b01));
    end
    @(posedge clk); #1;
    wght_ready = 1'b1;
    wait_idle("bp");

    // Back-to-back: idx 0 then idx 1 with valid held
    push_row(14'd100);
    push_row(14'd104);
    s = n_pop;
    @(posedge clk); #1;
    layer_base = 14'd100;
    spk_idx    = 12'd0;
    spk_valid  = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (spk_ready) done = 1'b1;
    end
    if (!done) note_fail("b2b first accept timeout");
    @(posedge clk); #1;
    spk_idx = 12'd1;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (spk_ready) begin
        done = 1'b1;
        chk("b2b_second_accept_after_drain", 66'((n_pop - s) >= 4), 66'(1));
      end
    end
    if (!done) note_fail("b2b second accept timeout");
    @(posedge clk); #1;
    spk_valid = 1'b0;
    wait_idle("b2b");

    // Reset after beat 2 of 4, then idx 5 streams 120..123
    push_row(14'd112);
    s = n_pop;
    send_spike(14'd100, 12'd3);
    wait_beats(s, 2);
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    push_row(14'd120);
    send_spike(14'd100, 12'd5);
    wait_idle("post_reset_row");

`ifdef WFETCH_PERF_EN
    do_reset();
    push_row(14'd100);
    s = n_pop;
    send_spike(14'd100, 12'd0);
    wait_beats(s, 1);
    wght_ready = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    wght_ready = 1'b1;
    wait_idle("perf1");
    push_row(14'd104);
    send_spike(14'd100, 12'd1);
    wait_idle("perf2");
    push_row(14'd108);
    send_spike(14'd100, 12'd2);
    wait_idle("perf3");
    send_spike(14'd10480, 12'd2);
    wait_idle("perf_err");
    chk("perf_evt_cnt",   66'(perf_evt_cnt),   66'(3));
    chk("perf_stall_cnt", 66'(perf_stall_cnt), 66'(4));
    chk("perf_err_cnt",   66'(perf_err_cnt),   66'(1));
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
